objective: RTL and testbench

- Training-side error stage at the output of the network.
- Consumes the 8-bit activation stream from the final logistic unit, plus a matching 8-bit target stream.
- In train mode, returns a Q8.8 signed feedback word (target minus activation, optionally scaled) to that unit's feedback port.
- Keeps saturating sample and misclassification counters for bench and host readout.

---
 rtl/objective.sv | 129 ++++++++++++
 tb/tb_objective.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/objective.sv
// Output-layer error stage: pairs activation/target samples, emits a scaled Q8.8
// feedback word in train mode, and keeps saturating sample/misclassification counts.
module objective #(
    parameter int SHIFT       = 0,   // supported range 0..22 (keeps the pre-saturation value inside 32 bits)
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   train,
    input  logic                   activation_valid,
    input  logic [7:0]             activation_data,
    output logic                   activation_ready,
    input  logic                   target_valid,
    input  logic [7:0]             target_data,
    output logic                   target_ready,
    output logic                   feedback_valid,
    output logic [15:0]            feedback_data,
    input  logic                   feedback_ready,
    output logic [COUNT_WIDTH-1:0] samples,
    output logic [COUNT_WIDTH-1:0] errors
);

    typedef enum logic {
        FILL,
        EMIT
    } state_t;

    state_t state, state_next;

    logic       activation_full, target_full;
    logic [7:0] activation_held, target_held;
    logic       consume, release_slots;

    logic signed [8:0]  difference;
    logic signed [31:0] shifted;
    logic [15:0]        feedback_next;

    // Ready is the registered slot-empty flag, so valid never reaches ready combinationally.
    assign activation_ready = ~activation_full;
    assign target_ready     = ~target_full;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next    = state;
        consume       = 1'b0;
        release_slots = 1'b0;
        case (state)
            FILL: begin
                if (activation_full && target_full) begin
                    consume = 1'b1;
                    if (train) begin
                        state_next = EMIT;
                    end else begin
                        release_slots = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (feedback_valid && feedback_ready) begin
                    release_slots = 1'b1;
                    state_next    = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Both operands are zero-extended so the 9-bit difference spans -255..+255.
    always_comb begin
        difference = $signed({1'b0, target_held}) - $signed({1'b0, activation_held});
        shifted    = 32'(difference) <<< SHIFT;
        if (shifted > 32'sd32767) begin
            feedback_next = 16'h7FFF;
        end else if (shifted < -32'sd32768) begin
            feedback_next = 16'h8000;
        end else begin
            feedback_next = shifted[15:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= FILL;
            activation_full <= 1'b0;
            target_full     <= 1'b0;
            activation_held <= '0;
            target_held     <= '0;
            feedback_valid  <= 1'b0;
            feedback_data   <= '0;
            samples         <= '0;
            errors          <= '0;
        end else begin
            state <= state_next;

            if (release_slots) begin
                activation_full <= 1'b0;
            end else if (activation_valid && activation_ready) begin
                activation_full <= 1'b1;
                activation_held <= activation_data;
            end

            if (release_slots) begin
                target_full <= 1'b0;
            end else if (target_valid && target_ready) begin
                target_full <= 1'b1;
                target_held <= target_data;
            end

            if (consume) begin
                if (samples != '1) begin
                    samples <= samples + COUNT_WIDTH'(1);
                end
                if ((activation_held[7] != target_held[7]) && (errors != '1)) begin
                    errors <= errors + COUNT_WIDTH'(1);
                end
                if (train) begin
                    feedback_valid <= 1'b1;
                    feedback_data  <= feedback_next;
                end
            end

            if (state == EMIT && feedback_valid && feedback_ready) begin
                feedback_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_objective.sv
// Directed bench for objective: a default instance plus a SHIFT=8 / 2-bit-counter
// instance driven by the same stimulus to cover shift saturation and counter saturation.
module tb_objective;

    logic        clock = 1'b0;
    logic        reset;
    logic        train;
    logic        activation_valid;
    logic [7:0]  activation_data;
    logic        target_valid;
    logic [7:0]  target_data;
    logic        feedback_ready;

    logic        activation_ready, target_ready, feedback_valid;
    logic [15:0] feedback_data;
    logic [15:0] samples, errors;

    logic        activation_ready_s8, target_ready_s8, feedback_valid_s8;
    logic [15:0] feedback_data_s8;
    logic [1:0]  samples_s8, errors_s8;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    objective #(.SHIFT(0), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .train(train),
        .activation_valid(activation_valid), .activation_data(activation_data),
        .activation_ready(activation_ready),
        .target_valid(target_valid), .target_data(target_data), .target_ready(target_ready),
        .feedback_valid(feedback_valid), .feedback_data(feedback_data),
        .feedback_ready(feedback_ready),
        .samples(samples), .errors(errors)
    );

    objective #(.SHIFT(8), .COUNT_WIDTH(2)) dut_s8 (
        .clock(clock), .reset(reset), .train(train),
        .activation_valid(activation_valid), .activation_data(activation_data),
        .activation_ready(activation_ready_s8),
        .target_valid(target_valid), .target_data(target_data), .target_ready(target_ready_s8),
        .feedback_valid(feedback_valid_s8), .feedback_data(feedback_data_s8),
        .feedback_ready(feedback_ready),
        .samples(samples_s8), .errors(errors_s8)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present both words together, then run to EMIT and check the held feedback word.
    task automatic train_pair(input logic [7:0] act, input logic [7:0] tgt,
                              input logic [15:0] exp_fb, input logic [15:0] exp_fb_s8);
        step();
        train            = 1'b1;
        feedback_ready   = 1'b0;
        activation_valid = 1'b1;
        activation_data  = act;
        target_valid     = 1'b1;
        target_data      = tgt;
        step();
        activation_valid = 1'b0;
        target_valid     = 1'b0;
        @(negedge clock);
        check("no_fb_before_consume", {31'd0, feedback_valid}, 32'd1 - 32'd1);
        step();
        @(negedge clock);
        check("fb_valid", {30'd0, feedback_valid, feedback_valid_s8}, 32'h3);
        check("fb_data", {16'd0, feedback_data}, {16'd0, exp_fb});
        check("fb_data_s8", {16'd0, feedback_data_s8}, {16'd0, exp_fb_s8});
    endtask

    task automatic complete_handshake();
        step();
        feedback_ready = 1'b1;
        step();
        feedback_ready = 1'b0;
        @(negedge clock);
        check("fb_cleared", {31'd0, feedback_valid}, 32'd0);
        check("ready_after_hs", {30'd0, activation_ready, target_ready}, 32'h3);
    endtask

    initial begin
        reset            = 1'b1;
        train            = 1'b0;
        activation_valid = 1'b0;
        activation_data  = '0;
        target_valid     = 1'b0;
        target_data      = '0;
        feedback_ready   = 1'b0;

        // Reset state
        step();
        step();
        @(negedge clock);
        check("rst_readys", {30'd0, activation_ready, target_ready}, 32'h3);
        check("rst_fb_valid", {31'd0, feedback_valid}, 32'd0);
        check("rst_samples", {16'd0, samples}, 32'd0);
        check("rst_errors", {16'd0, errors}, 32'd0);
        step();
        reset = 1'b0;

        // Equal words: zero feedback, no error
        train_pair(8'h80, 8'h80, 16'h0000, 16'h0000);
        check("p1_samples", {16'd0, samples}, 32'd1);
        check("p1_errors", {16'd0, errors}, 32'd0);
        complete_handshake();

        // Most negative difference: -255, and saturation to 0x8000 when shifted
        train_pair(8'hFF, 8'h00, 16'hFF01, 16'h8000);
        check("p2_errors", {16'd0, errors}, 32'd1);
        complete_handshake();

        // Most positive difference: +255, and saturation to 0x7FFF when shifted
        train_pair(8'h00, 8'hFF, 16'h00FF, 16'h7FFF);
        check("p3_samples", {16'd0, samples}, 32'd3);
        check("p3_errors", {16'd0, errors}, 32'd2);
        check("p3_samples_s8", {30'd0, samples_s8}, 32'd3);
        complete_handshake();

        // Target three cycles behind the activation, then five cycles of backpressure
        step();
        train            = 1'b1;
        activation_valid = 1'b1;
        activation_data  = 8'h40;
        step();
        activation_valid = 1'b0;
        @(negedge clock);
        check("skew_readys", {30'd0, activation_ready, target_ready}, 32'h1);
        step();
        step();
        target_valid = 1'b1;
        target_data  = 8'h10;
        step();
        target_valid = 1'b0;
        step();
        train = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_fb_valid", {31'd0, feedback_valid}, 32'd1);
            check("bp_fb_data", {16'd0, feedback_data}, 32'h0000_FFD0);
            check("bp_fb_data_s8", {16'd0, feedback_data_s8}, 32'h0000_D000);
            check("bp_readys", {30'd0, activation_ready, target_ready}, 32'd0);
        end
        check("skew_samples_s8_hold", {30'd0, samples_s8}, 32'd3);
        complete_handshake();

        // train = 0: counted but no feedback, slots released after consumption
        step();
        train            = 1'b0;
        activation_valid = 1'b1;
        activation_data  = 8'hC0;
        target_valid     = 1'b1;
        target_data      = 8'h20;
        step();
        activation_valid = 1'b0;
        target_valid     = 1'b0;
        @(negedge clock);
        check("nt_readys_low", {30'd0, activation_ready, target_ready}, 32'd0);
        step();
        @(negedge clock);
        check("nt_no_fb", {30'd0, feedback_valid, feedback_valid_s8}, 32'd0);
        check("nt_readys_back", {30'd0, activation_ready, target_ready}, 32'h3);
        check("nt_samples", {16'd0, samples}, 32'd5);
        check("nt_errors", {16'd0, errors}, 32'd3);
        check("nt_errors_s8", {30'd0, errors_s8}, 32'd3);

        // Train pair, then reset while the feedback word is pending
        train_pair(8'hFF, 8'h00, 16'hFF01, 16'h8000);
        check("p6_errors", {16'd0, errors}, 32'd4);
        check("p6_errors_s8_hold", {30'd0, errors_s8}, 32'd3);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check("emit_rst_fb_valid", {30'd0, feedback_valid, feedback_valid_s8}, 32'd0);
        check("emit_rst_fb_data", {16'd0, feedback_data}, 32'd0);
        check("emit_rst_counts", {samples, errors}, 32'd0);
        check("emit_rst_readys", {30'd0, activation_ready, target_ready}, 32'h3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
